// File: rtl/spi_pin_arbiter_if.sv
// Host-side and pin-side signals of the shared SPI pin arbiter.
// The slave modport is the arbiter. The master modport is whatever drives the hosts and the pins.
interface spi_pin_arbiter_if #(
    parameter int unsigned NumReq = 3
);
    // Per-host side
    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] gnt_o;
    logic [NumReq-1:0] sclk_i;
    logic [NumReq-1:0] copi_i;
    logic [NumReq-1:0] cs_ni;
    logic [NumReq-1:0] cipo_o;
    // Pin side
    logic              sclk_o;
    logic              copi_o;
    logic              cs_no;
    logic              cipo_i;
    logic              timeout_o;

    modport slave (
        input  req_i, sclk_i, copi_i, cs_ni, cipo_i,
        output gnt_o, cipo_o, sclk_o, copi_o, cs_no, timeout_o
    );

    modport master (
        output req_i, sclk_i, copi_i, cs_ni, cipo_i,
        input  gnt_o, cipo_o, sclk_o, copi_o, cs_no, timeout_o
    );
endinterface

// File: rtl/spi_pin_arbiter.sv
// Round-robin sharing of one set of SPI pins between NumReq host requesters.
// The owner keeps the pins until it drops its request with CS high.
// A forced CS-high guard gap separates owners.
// An optional watchdog revokes an owner that holds the pins too long.
module spi_pin_arbiter #(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned GapCycles     = 4,
    parameter int unsigned TimeoutCycles = 0,
    parameter logic        IdleSclk      = 1'b0
) (
    input logic              clk_i,
    input logic              rst_i,
    spi_pin_arbiter_if.slave bus
);
    localparam int unsigned OwnW   = $clog2(NumReq);
    localparam int unsigned CntMax = (TimeoutCycles > GapCycles) ? TimeoutCycles : GapCycles;
    localparam int unsigned CntW   = $clog2((CntMax > 2) ? CntMax : 2);
    localparam logic [CntW-1:0] GapLast  = CntW'((GapCycles > 0) ? GapCycles - 1 : 0);
    localparam logic [CntW-1:0] HoldLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

    state_t          state;
    logic [OwnW-1:0] owner;
    logic [OwnW-1:0] rr_ptr;
    logic [CntW-1:0] hold_cnt;
    logic [CntW-1:0] gap_cnt;
    logic [OwnW-1:0] pick;
    logic            pick_vld;
    logic            release_ok;
    logic            expire;
    int unsigned     idx;

    // First requester found searching upward from the slot after the last owner.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!pick_vld && bus.req_i[idx[OwnW-1:0]]) begin
                pick     = idx[OwnW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Release and watchdog expiry conditions for the current owner.
    always_comb begin
        release_ok = (state == OWNED) && !bus.req_i[owner] && bus.cs_ni[owner];
        expire     = (TimeoutCycles != 0) && (state == OWNED) && (hold_cnt == HoldLast);
    end

    // Pin mux. The owner drives the pins. Otherwise the pins sit idle with CS high.
    // Because state resets asynchronously, the pins go idle as soon as reset asserts.
    always_comb begin
        bus.sclk_o = IdleSclk;
        bus.copi_o = 1'b0;
        bus.cs_no  = 1'b1;
        bus.cipo_o = '0;
        if (state == OWNED) begin
            bus.sclk_o        = bus.sclk_i[owner];
            bus.copi_o        = bus.copi_i[owner];
            bus.cs_no         = bus.cs_ni[owner];
            bus.cipo_o[owner] = bus.cipo_i;
        end
    end

    // Ownership FSM with registered grant and timeout pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= OwnW'(NumReq - 1);
            hold_cnt      <= '0;
            gap_cnt       <= '0;
            bus.gnt_o     <= '0;
            bus.timeout_o <= 1'b0;
        end else begin
            bus.timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner     <= pick;
                        rr_ptr    <= pick;
                        hold_cnt  <= '0;
                        bus.gnt_o <= NumReq'(1) << pick;
                        state     <= OWNED;
                    end
                end
                OWNED: begin
                    // A normal release wins over an expiry in the same cycle.
                    if (release_ok || expire) begin
                        bus.gnt_o     <= '0;
                        bus.timeout_o <= !release_ok;
                        gap_cnt       <= '0;
                        state         <= (GapCycles == 0) ? IDLE : GAP;
                    end else if (TimeoutCycles != 0) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GapLast) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_pin_arbiter.sv
// Self-checking bench for spi_pin_arbiter.
// Instance A: GapCycles=4, TimeoutCycles=16. Instance B: GapCycles=0, watchdog off.
// Both instances see the same stimulus, and a tenure-level model checks every cycle.
module tb_spi_pin_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req, csn, sclk, copi;
    logic cipo;

    always #5 clk = ~clk;

    spi_pin_arbiter_if #(.NumReq(N)) bus_a ();
    spi_pin_arbiter_if #(.NumReq(N)) bus_b ();

    assign bus_a.req_i  = req;
    assign bus_a.cs_ni  = csn;
    assign bus_a.sclk_i = sclk;
    assign bus_a.copi_i = copi;
    assign bus_a.cipo_i = cipo;
    assign bus_b.req_i  = req;
    assign bus_b.cs_ni  = csn;
    assign bus_b.sclk_i = sclk;
    assign bus_b.copi_i = copi;
    assign bus_b.cipo_i = cipo;

    spi_pin_arbiter #(.NumReq(N), .GapCycles(4), .TimeoutCycles(16), .IdleSclk(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a)
    );
    spi_pin_arbiter #(.NumReq(N), .GapCycles(0), .TimeoutCycles(0), .IdleSclk(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the pins, how long the CS-high cooldown still runs,
    // how long the current tenure has lasted, and who was granted last.
    int m_own[2], m_wait[2], m_held[2], m_last[2];
    bit m_to[2];
    int gap_p[2] = '{4, 0};
    int tmo_p[2] = '{16, 0};

    logic [N-1:0] s_gnt_a, s_gnt_b;
    logic s_cs_a, s_to_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_wait[k] = 0;
            m_held[k] = 0;
            m_last[k] = N - 1;
            m_to[k]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_to[k] = 1'b0;
            if (m_own[k] >= 0) begin
                logic [1:0] o;
                bit rel, ex;
                o = 2'(m_own[k]);
                m_held[k]++;
                rel = !req[o] && csn[o];
                ex  = (tmo_p[k] > 0) && (m_held[k] == tmo_p[k]);
                if (rel || ex) begin
                    m_to[k]   = ex && !rel;
                    m_own[k]  = -1;
                    m_wait[k] = gap_p[k];
                end
            end else if (m_wait[k] > 0) begin
                m_wait[k]--;
            end else if (req != 0) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_last[k] + i) % N;
                    if (req[2'(c)]) begin
                        m_own[k]  = c;
                        m_last[k] = c;
                        m_held[k] = 0;
                        break;
                    end
                end
            end
        end
    endtask

    // Expected {gnt, cipo_o, sclk_o, copi_o, cs_no, timeout_o}.
    function automatic logic [9:0] model_out(input int k);
        logic [2:0] g, ci;
        logic s, c, cs;
        logic [1:0] o;
        g = '0; ci = '0; s = 1'b0; c = 1'b0; cs = 1'b1;
        if (m_own[k] >= 0) begin
            o  = 2'(m_own[k]);
            g  = 3'b001 << o;
            ci = cipo ? g : 3'b000;
            s  = sclk[o];
            c  = copi[o];
            cs = csn[o];
        end
        return {g, ci, s, c, cs, m_to[k]};
    endfunction

    // One cycle: inputs are already applied. Compare both instances against the model,
    // sample a few outputs for the directed checks, then clock the model with the DUTs.
    task automatic tick();
        #1;
        chk("model_a", 32'({bus_a.gnt_o, bus_a.cipo_o, bus_a.sclk_o, bus_a.copi_o, bus_a.cs_no,
                            bus_a.timeout_o}), 32'(model_out(0)));
        chk("model_b", 32'({bus_b.gnt_o, bus_b.cipo_o, bus_b.sclk_o, bus_b.copi_o, bus_b.cs_no,
                            bus_b.timeout_o}), 32'(model_out(1)));
        s_gnt_a = bus_a.gnt_o;
        s_gnt_b = bus_b.gnt_o;
        s_cs_a  = bus_a.cs_no;
        s_to_a  = bus_a.timeout_o;
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req = '0; csn = '1; sclk = '0; copi = '0; cipo = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] req, csn, sclk, copi;
        logic       cipo;
        logic [2:0] e_gnt, e_cipo;
        logic       e_sclk, e_copi, e_cs;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] got;
        logic [2:0] rr_exp[4];
        int zeros, n_own;

        // Single host 1, protected release, ignored requests, guard gap, next owner (instance A).
        //           req     csn     sclk    copi   cipo  gnt     cipo_o  sclk  copi  cs
        tbl[0]  = '{3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3'b010, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3'b010, 3'b101, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{3'b010, 3'b101, 3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'b000, 3'b101, 3'b010, 3'b000, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{3'b101, 3'b101, 3'b000, 3'b010, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'b101, 3'b101, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{3'b101, 3'b101, 3'b101, 3'b000, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'b101, 3'b101, 3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'b101, 3'b111, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{3'b101, 3'b111, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{3'b101, 3'b111, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{3'b101, 3'b111, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{3'b101, 3'b111, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{3'b101, 3'b111, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{3'b101, 3'b011, 3'b100, 3'b000, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{3'b100, 3'b111, 3'b000, 3'b100, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 1'b1};
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        for (int r = 0; r < 17; r++) begin
            req = tbl[r].req; csn = tbl[r].csn; sclk = tbl[r].sclk;
            copi = tbl[r].copi; cipo = tbl[r].cipo;
            #1;
            chk($sformatf("tbl%0d_gnt", r), 32'(bus_a.gnt_o), 32'(tbl[r].e_gnt));
            chk($sformatf("tbl%0d_cipo", r), 32'(bus_a.cipo_o), 32'(tbl[r].e_cipo));
            chk($sformatf("tbl%0d_sclk", r), 32'(bus_a.sclk_o), 32'(tbl[r].e_sclk));
            chk($sformatf("tbl%0d_copi", r), 32'(bus_a.copi_o), 32'(tbl[r].e_copi));
            chk($sformatf("tbl%0d_cs", r), 32'(bus_a.cs_no), 32'(tbl[r].e_cs));
            tick();
        end

        // Reset mid-tenure with host 1 holding CS low. The pins must idle at once.
        idle_inputs();
        do_reset();
        req = 3'b010;
        for (int i = 0; i < 3; i++) tick();
        csn = 3'b101;
        sclk = 3'b010;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_cs_async", 32'(bus_a.cs_no), 32'(1));
        chk("rst_gnt_async", 32'(bus_a.gnt_o), 32'(0));
        chk("rst_sclk_async", 32'(bus_a.sclk_o), 32'(0));
        model_reset();
        tick();
        rst = 1'b0;
        req = 3'b111;
        csn = 3'b111;
        sclk = '0;
        tick();
        tick();
        chk("rst_first_winner", 32'(s_gnt_a), 32'(3'b001));

        // Round robin with all hosts requesting and 10-cycle tenures.
        idle_inputs();
        do_reset();
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            got = '0;
            zeros = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (s_gnt_a != 0) begin
                    got = s_gnt_a;
                    break;
                end
                zeros++;
            end
            chk($sformatf("rr_order%0d", t), 32'(got), 32'(rr_exp[t]));
            if (t > 0) chk($sformatf("rr_gap%0d", t), 32'(zeros), 32'(5));
            csn = ~got;
            for (int i = 0; i < 10; i++) begin
                sclk = 3'($urandom_range(0, 7));
                tick();
            end
            req = 3'b111 & ~got;
            csn = 3'b111;
            tick();
            req = 3'b111;
        end

        // Watchdog: host 2 never lets go.
        idle_inputs();
        do_reset();
        req = 3'b100;
        csn = 3'b011;
        got = '0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick();
            got = s_gnt_a;
        end
        chk("wd_grant", 32'(got), 32'(3'b100));
        n_own = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_gnt_a != 3'b100) break;
            n_own++;
        end
        chk("wd_hold_cycles", 32'(n_own), 32'(16));
        chk("wd_pulse", 32'(s_to_a), 32'(1));
        chk("wd_cs_idle", 32'(s_cs_a), 32'(1));
        tick();
        chk("wd_pulse_once", 32'(s_to_a), 32'(0));
        req = '0;
        csn = 3'b111;
        for (int i = 0; i < 8; i++) tick();

        // Release on the very cycle the watchdog would fire: no timeout.
        do_reset();
        req = 3'b001;
        csn = 3'b110;
        got = '0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick();
            got = s_gnt_a;
        end
        chk("prec_grant", 32'(got), 32'(3'b001));
        for (int n = 2; n <= 16; n++) begin
            if (n == 16) begin
                req = '0;
                csn = 3'b111;
            end
            tick();
        end
        tick();
        chk("prec_no_timeout", 32'(s_to_a), 32'(0));
        chk("prec_released", 32'(s_gnt_a), 32'(0));

        // No guard gap (instance B): release with host 1 pending.
        idle_inputs();
        do_reset();
        req = 3'b011;
        got = '0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick();
            got = s_gnt_b;
        end
        chk("g0_grant", 32'(got), 32'(3'b001));
        csn = 3'b110;
        for (int i = 0; i < 3; i++) tick();
        req = 3'b010;
        csn = 3'b111;
        tick();
        tick();
        chk("g0_idle", 32'(s_gnt_b), 32'(0));
        tick();
        chk("g0_next", 32'(s_gnt_b), 32'(3'b010));

        // Random traffic with periodic stuck-owner stretches and a mid-run reset.
        idle_inputs();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
            if ((cyc % 300) >= 250) begin
                req = 3'b111;
                csn = 3'b000;
            end else begin
                if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
                csn = 3'($urandom_range(0, 7));
            end
            sclk = 3'($urandom_range(0, 7));
            copi = 3'($urandom_range(0, 7));
            cipo = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
